// File: rtl/lcd_pkg.sv
// Shared constants, init table and FSM state type for the HD44780 character-LCD driver.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_OFF  = 8'h08;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [6:0] ROW1_OFF  = 7'h40;
    localparam logic [7:0] BLANK     = 8'h20;

    typedef enum logic [2:0] {
        StClrBuf,
        StInitCmd,
        StRowAddr,
        StChar,
        StDrop,
        StHold
    } lcd_state_e;

    // Four function-set writes force 8-bit mode regardless of the panel's prior state.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        cmd = FUNC_SET;
        unique case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: cmd = FUNC_SET;
            3'd4:                   cmd = DISP_OFF;
            3'd5:                   cmd = CLEAR;
            3'd6:                   cmd = DISP_ON;
            3'd7:                   cmd = ENTRY;
            default:                cmd = FUNC_SET;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? {4'h3, n} : 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Rows 2 and 3 continue rows 0 and 1 in DDRAM on 4-line panels.
    function automatic logic [6:0] row_offset(input logic [1:0] row, input int unsigned cols);
        logic [6:0] off;
        off = 7'h00;
        unique case (row)
            2'd0:    off = 7'h00;
            2'd1:    off = ROW1_OFF;
            2'd2:    off = 7'(cols);
            2'd3:    off = ROW1_OFF + 7'(cols);
            default: off = 7'h00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// Simple dual-port character buffer: synchronous write, synchronous read-old-data.
module lcd_char_ram #(
    parameter int unsigned Depth = 32,
    parameter int unsigned AddrW = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/lcd_char_controller.sv
// HD44780 character-LCD driver: clears a host-writable text buffer, runs the init
// sequence, then refreshes the panel continuously from the buffer.
module lcd_char_controller
    import lcd_pkg::*;
#(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 2,
    parameter int unsigned TICK_DIV = 125000
) (
    input  logic                         iCLK_50MHZ,
    input  logic                         iRST_N,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(ROWS*COLS)-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic                         wr_hex,
    output logic                         init_done,
    output logic                         frame_done,
    output logic                         LCD_RS,
    output logic                         LCD_E,
    output logic                         LCD_RW,
    inout  wire  [7:0]                   DATA_BUS
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt_q;
    logic          tick_en;

    lcd_state_e    state_q, next_q;
    logic [AW-1:0] clr_idx_q;
    logic [2:0]    init_idx_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          frame_last_q;
    logic          lcd_e_q, lcd_rs_q, wr_ready_q, init_done_q, frame_done_q;
    logic [7:0]    bus_q;

    logic          ram_we;
    logic [AW-1:0] ram_waddr, rd_addr;
    logic [7:0]    ram_wdata, rd_data;
    logic          in_range, last_col, last_row;

    assign tick_en = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            tick_cnt_q <= '0;
        end else if (tick_en) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign in_range = (32'(wr_addr) < CELLS);
    assign rd_addr  = AW'(32'(row_q) * COLS + 32'(col_q));
    assign last_col = (col_q == CW'(COLS - 1));
    assign last_row = (row_q == RW'(ROWS - 1));

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_hex ? hex_ascii(wr_data[3:0]) : wr_data;
        if (state_q == StClrBuf) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx_q;
            ram_wdata = BLANK;
        end else if (wr_valid && wr_ready_q && in_range) begin
            ram_we = 1'b1;
        end
    end

    lcd_char_ram #(
        .Depth (CELLS),
        .AddrW (AW)
    ) u_ram (
        .clk_i   (iCLK_50MHZ),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // SEND states raise E and load the bus; DROP and HOLD are shared, HOLD resumes next_q.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= StClrBuf;
            next_q       <= StInitCmd;
            clr_idx_q    <= '0;
            init_idx_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_last_q <= 1'b0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            bus_q        <= 8'h00;
            wr_ready_q   <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (state_q == StClrBuf) begin
                clr_idx_q <= clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(CELLS - 1)) begin
                    wr_ready_q <= 1'b1;
                    state_q    <= StInitCmd;
                end
            end else if (tick_en) begin
                unique case (state_q)
                    StInitCmd: begin
                        lcd_e_q    <= 1'b1;
                        lcd_rs_q   <= 1'b0;
                        bus_q      <= init_cmd(init_idx_q);
                        init_idx_q <= init_idx_q + 1'b1;
                        next_q     <= (init_idx_q == 3'd7) ? StRowAddr : StInitCmd;
                        state_q    <= StDrop;
                    end
                    StRowAddr: begin
                        lcd_e_q  <= 1'b1;
                        lcd_rs_q <= 1'b0;
                        bus_q    <= SET_DDRAM | {1'b0, row_offset(2'(row_q), COLS)};
                        col_q    <= '0;
                        next_q   <= StChar;
                        state_q  <= StDrop;
                    end
                    StChar: begin
                        lcd_e_q  <= 1'b1;
                        lcd_rs_q <= 1'b1;
                        bus_q    <= rd_data;
                        state_q  <= StDrop;
                        if (last_col) begin
                            col_q        <= '0;
                            row_q        <= last_row ? '0 : row_q + 1'b1;
                            frame_last_q <= last_row;
                            next_q       <= StRowAddr;
                        end else begin
                            col_q  <= col_q + 1'b1;
                            next_q <= StChar;
                        end
                    end
                    StDrop: begin
                        lcd_e_q <= 1'b0;
                        state_q <= StHold;
                    end
                    StHold: begin
                        if (next_q == StRowAddr) begin
                            init_done_q <= 1'b1;
                        end
                        frame_done_q <= frame_last_q;
                        frame_last_q <= 1'b0;
                        state_q      <= next_q;
                    end
                    default: state_q <= StClrBuf;
                endcase
            end
        end
    end

    assign wr_ready   = wr_ready_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign LCD_E      = lcd_e_q;
    assign LCD_RS     = lcd_rs_q;
    assign LCD_RW     = 1'b0;
    assign DATA_BUS   = LCD_RW ? 8'hzz : bus_q;

endmodule

// File: tb/tb_lcd_char_controller.sv
// Directed bench: 2x16 instance for init/refresh/write/reset scenarios, 4x20 for row mapping.
module tb_lcd_char_controller;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic       rst_a_n, wr_valid_a, wr_hex_a, wr_ready_a, init_done_a, frame_done_a;
    logic       e_a, rs_a, rw_a;
    logic [4:0] wr_addr_a;
    logic [7:0] wr_data_a;
    wire  [7:0] bus_a;

    logic       rst_b_n, wr_valid_b, wr_hex_b, wr_ready_b, init_done_b, frame_done_b;
    logic       e_b, rs_b, rw_b;
    logic [6:0] wr_addr_b;
    logic [7:0] wr_data_b;
    wire  [7:0] bus_b;

    lcd_char_controller #(.COLS(16), .ROWS(2), .TICK_DIV(4)) dut_a (
        .iCLK_50MHZ (clk),        .iRST_N     (rst_a_n),
        .wr_valid   (wr_valid_a), .wr_ready   (wr_ready_a),
        .wr_addr    (wr_addr_a),  .wr_data    (wr_data_a),
        .wr_hex     (wr_hex_a),   .init_done  (init_done_a),
        .frame_done (frame_done_a),
        .LCD_RS     (rs_a),       .LCD_E      (e_a),
        .LCD_RW     (rw_a),       .DATA_BUS   (bus_a)
    );

    lcd_char_controller #(.COLS(20), .ROWS(4), .TICK_DIV(4)) dut_b (
        .iCLK_50MHZ (clk),        .iRST_N     (rst_b_n),
        .wr_valid   (wr_valid_b), .wr_ready   (wr_ready_b),
        .wr_addr    (wr_addr_b),  .wr_data    (wr_data_b),
        .wr_hex     (wr_hex_b),   .init_done  (init_done_b),
        .frame_done (frame_done_b),
        .LCD_RS     (rs_b),       .LCD_E      (e_b),
        .LCD_RW     (rw_b),       .DATA_BUS   (bus_b)
    );

    // Bus monitors: {RS, DATA} captured on every falling edge of E.
    logic [8:0] log_a[$];
    logic [8:0] log_b[$];
    always @(negedge e_a) log_a.push_back({rs_a, bus_a});
    always @(negedge e_b) log_b.push_back({rs_b, bus_b});

    logic [7:0] mem_a [32];
    logic [7:0] init_exp [8];

    function automatic logic [8:0] exp_a(input int k);
        if (k == 0)       return 9'h080;
        else if (k <= 16) return {1'b1, mem_a[k-1]};
        else if (k == 17) return 9'h0C0;
        else              return {1'b1, mem_a[k-2]};
    endfunction

    task automatic wait_log_a(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (log_a.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_log_b(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (log_b.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_frame_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (frame_done_a === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_frame_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (frame_done_b === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic write_a(input logic [4:0] addr, input logic [7:0] data, input logic hex);
        wr_addr_a = addr; wr_data_a = data; wr_hex_a = hex; wr_valid_a = 1'b1;
        total++;
        if (wr_ready_a !== 1'b1) $display("FAIL write_ready_a: got %b want 1", wr_ready_a);
        else passed++;
        @(posedge clk); #1;
        wr_valid_a = 1'b0; wr_hex_a = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        rst_a_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 7;
        if (e_a !== 1'b0) $display("FAIL rst_e: got %b want 0", e_a); else passed++;
        if (rs_a !== 1'b0) $display("FAIL rst_rs: got %b want 0", rs_a); else passed++;
        if (rw_a !== 1'b0) $display("FAIL rst_rw: got %b want 0", rw_a); else passed++;
        if (bus_a !== 8'h00) $display("FAIL rst_bus: got %h want 00", bus_a); else passed++;
        if (wr_ready_a !== 1'b0) $display("FAIL rst_ready: got %b want 0", wr_ready_a);
        else passed++;
        if (init_done_a !== 1'b0) $display("FAIL rst_init_done: got %b want 0", init_done_a);
        else passed++;
        if (frame_done_a !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done_a);
        else passed++;
        for (int i = 0; i < 32; i++) mem_a[i] = 8'h20;
        rst_a_n = 1'b1;
        log_a.delete();
        cnt = 0;
        while (wr_ready_a !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        total++;
        if (cnt != 32) $display("FAIL ready_latency: got %0d cycles want 32", cnt);
        else passed++;
    endtask

    task automatic test_init();
        bit ok;
        wait_log_a(8, ok);
        total++;
        if (!ok) $display("FAIL init_timeout: got %0d bytes want 8", log_a.size());
        else passed++;
        total++;
        if (init_done_a !== 1'b0) $display("FAIL init_done_early: got %b want 0", init_done_a);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (log_a.size() <= i || log_a[i] !== {1'b0, init_exp[i]})
                $display("FAIL init_byte%0d: got %h want %h", i,
                         (log_a.size() > i) ? log_a[i] : 9'h1FF, {1'b0, init_exp[i]});
            else passed++;
        end
        for (int i = 0; i < 50 && e_a !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (init_done_a !== 1'b1) $display("FAIL init_done: got %b want 1", init_done_a);
        else passed++;
    endtask

    task automatic check_pass_a(input int base, input string tag);
        for (int k = 0; k < 34; k++) begin
            total++;
            if (log_a.size() <= base + k || log_a[base+k] !== exp_a(k))
                $display("FAIL %s_byte%0d: got %h want %h", tag, k,
                         (log_a.size() > base + k) ? log_a[base+k] : 9'h1FF, exp_a(k));
            else passed++;
        end
    endtask

    task automatic test_blank_frame();
        bit ok;
        int width;
        wait_log_a(42, ok);
        total++;
        if (!ok) $display("FAIL blank_timeout: got %0d bytes want 42", log_a.size());
        else passed++;
        check_pass_a(8, "blank");
        wait_frame_a(ok);
        total++;
        if (!ok) $display("FAIL frame_done_timeout: got 0 want 1");
        else passed++;
        total++;
        if (log_a.size() != 42) $display("FAIL frame_done_pos: got %0d bytes want 42",
                                         log_a.size());
        else passed++;
        width = 0;
        while (frame_done_a === 1'b1 && width < 10) begin
            width++;
            @(posedge clk); #1;
        end
        total++;
        if (width != 1) $display("FAIL frame_done_width: got %0d want 1", width);
        else passed++;
    endtask

    task automatic test_hex_write();
        bit ok;
        log_a.delete();
        write_a(5'd0, 8'h53, 1'b0);
        write_a(5'd17, 8'hFB, 1'b1);
        write_a(5'd18, 8'h07, 1'b1);
        mem_a[0] = 8'h53; mem_a[17] = 8'h42; mem_a[18] = 8'h37;
        wait_log_a(68, ok);
        total++;
        if (!ok) $display("FAIL hex_timeout: got %0d bytes want 68", log_a.size());
        else passed++;
        check_pass_a(34, "hex");
    endtask

    task automatic test_collision();
        bit ok;
        wait_frame_a(ok);
        log_a.delete();
        wait_log_a(5, ok);
        for (int i = 0; i < 50 && e_a !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        // Cell 5's read cycle is 11 clocks after cell 4's E rise at TICK_DIV=4.
        repeat (10) @(posedge clk);
        #1;
        write_a(5'd5, 8'h58, 1'b0);
        wait_log_a(7, ok);
        total++;
        if (log_a.size() < 7 || log_a[6] !== 9'h120)
            $display("FAIL collide_old: got %h want 120",
                     (log_a.size() >= 7) ? log_a[6] : 9'h1FF);
        else passed++;
        mem_a[5] = 8'h58;
        wait_log_a(68, ok);
        total++;
        if (!ok) $display("FAIL collide_timeout: got %0d bytes want 68", log_a.size());
        else passed++;
        check_pass_a(34, "collide");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 100 && !(e_a === 1'b1 && rs_a === 1'b1); i++) begin
            @(posedge clk); #1;
        end
        #3 rst_a_n = 1'b0;
        #1;
        total += 4;
        if (e_a !== 1'b0) $display("FAIL midrst_e: got %b want 0", e_a); else passed++;
        if (wr_ready_a !== 1'b0) $display("FAIL midrst_ready: got %b want 0", wr_ready_a);
        else passed++;
        if (init_done_a !== 1'b0) $display("FAIL midrst_init_done: got %b want 0", init_done_a);
        else passed++;
        if (bus_a !== 8'h00) $display("FAIL midrst_bus: got %h want 00", bus_a); else passed++;
        @(posedge clk); #1;
        test_reset();
        test_init();
    endtask

    task automatic test_rows4();
        bit ok;
        logic [8:0] want;
        logic [7:0] rcmd [4];
        rcmd[0] = 8'h80; rcmd[1] = 8'hC0; rcmd[2] = 8'h94; rcmd[3] = 8'hD4;
        for (int i = 0; i < 2000 && init_done_b !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        wr_addr_b = 7'd100; wr_data_b = 8'h5A; wr_hex_b = 1'b0; wr_valid_b = 1'b1;
        total++;
        if (wr_ready_b !== 1'b1) $display("FAIL oob_ready: got %b want 1", wr_ready_b);
        else passed++;
        @(posedge clk); #1;
        wr_addr_b = 7'd41; wr_data_b = 8'h0A; wr_hex_b = 1'b1;
        @(posedge clk); #1;
        wr_valid_b = 1'b0; wr_hex_b = 1'b0;
        wait_frame_b(ok);
        log_b.delete();
        wait_log_b(84, ok);
        total++;
        if (!ok) $display("FAIL rows4_timeout: got %0d bytes want 84", log_b.size());
        else passed++;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 21; k++) begin
                if (k == 0) want = {1'b0, rcmd[r]};
                else if (r == 2 && k == 2) want = 9'h141;
                else want = 9'h120;
                total++;
                if (log_b.size() <= r*21 + k || log_b[r*21+k] !== want)
                    $display("FAIL rows4_r%0d_b%0d: got %h want %h", r, k,
                             (log_b.size() > r*21 + k) ? log_b[r*21+k] : 9'h1FF, want);
                else passed++;
            end
        end
    endtask

    initial begin
        init_exp[0] = 8'h38; init_exp[1] = 8'h38; init_exp[2] = 8'h38; init_exp[3] = 8'h38;
        init_exp[4] = 8'h08; init_exp[5] = 8'h01; init_exp[6] = 8'h0C; init_exp[7] = 8'h06;
        rst_a_n = 1'b0; wr_valid_a = 1'b0; wr_hex_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        rst_b_n = 1'b0; wr_valid_b = 1'b0; wr_hex_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_b_n = 1'b1;
        test_reset();
        test_init();
        test_blank_frame();
        test_hex_write();
        test_collision();
        test_reset_mid();
        test_rows4();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
